// File: rtl/bit_serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// bsa_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   state_t  : FSM state encoding (IDLE / SHIFT / DONE)
//   MODE_ADD : value of 'sub' that selects a + b
//   MODE_SUB : value of 'sub' that selects a - b
// ---------------------------------------------------------------------------
package bsa_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_addsub_if.sv
// ---------------------------------------------------------------------------
// bit_serial_addsub_if
// Request/response bundle of the bit-serial adder/subtractor.
//   start  : request, only honoured while the unit is idle
//   sub    : 0 = a + b, 1 = a - b (captured with start)
//   a, b   : WIDTH-bit operands (captured with start)
//   busy   : high while bit pairs are being processed
//   done   : one-cycle pulse, result/cout/ovf valid
//   result : sum or difference, held until the next accepted start
//   cout   : final carry (for subtraction 1 = no borrow)
//   ovf    : signed two's-complement overflow
// Modports: master drives the request, slave is the arithmetic unit.
// ---------------------------------------------------------------------------
interface bit_serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/bit_serial_addsub_fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Single-bit full adder; the only arithmetic element of the serial unit.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
// Purely combinational.
// ---------------------------------------------------------------------------
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/bit_serial_addsub.sv
// ---------------------------------------------------------------------------
// bit_serial_addsub
// LSB-first serial adder/subtractor. Operands are loaded on an accepted
// start, then one bit pair per clock goes through a single full-adder cell
// whose carry is kept in a flop. The sum bits are collected MSB-first into
// a right-shifting result register, so after WIDTH shifts the word is
// aligned. A one-cycle done pulse reports result, cout and ovf.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response bundle (slave side)
// ---------------------------------------------------------------------------
module bit_serial_addsub
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_serial_addsub_if.slave   bus
);

  localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;

  fa_cell u_fa_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Subtraction is a + ~b + 1: b is inverted at load time and the +1 comes
  // in as the initial carry. On the last bit r_carry is the carry into the
  // MSB, so XOR with the cell's carry out gives signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_cout  <= w_cout;
            r_ovf   <= r_carry ^ w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_addsub
// Directed bench for bit_serial_addsub: an 8-bit instance for the named
// scenarios and a 3-bit instance swept over every operand pair.
// ---------------------------------------------------------------------------
module tb_bit_serial_addsub;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  bit_serial_addsub_if #(.WIDTH(8)) bus8 ();
  bit_serial_addsub_if #(.WIDTH(3)) bus3 ();

  bit_serial_addsub #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  bit_serial_addsub #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one request on the selected instance for exactly one rising edge;
  // returns just after the accepting edge with start already dropped
  task automatic applyStimulus(input bit narrow, input logic sub,
                               input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if (narrow) begin
      bus3.start = 1'b1; bus3.sub = sub; bus3.a = a[2:0]; bus3.b = b[2:0];
    end else begin
      bus8.start = 1'b1; bus8.sub = sub; bus8.a = a; bus8.b = b;
    end
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    bus8.start = 1'b0;
  endtask

  // Wait (bounded) for done after an accepting edge; reports how many edges
  // it took and how many cycles busy was observed high
  task automatic waitDone(input bit narrow, output int edges, output int busyCycles);
    logic d;
    logic bz;
    edges = 0;
    busyCycles = 0;
    @(negedge clk);
    d  = narrow ? bus3.done : bus8.done;
    bz = narrow ? bus3.busy : bus8.busy;
    while (!d && edges < 40) begin
      if (bz) busyCycles++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      d  = narrow ? bus3.done : bus8.done;
      bz = narrow ? bus3.busy : bus8.busy;
    end
    checkOutput("done_seen", 32'(d), 32'd1);
  endtask

  // Full 8-bit operation: checks latency, busy length, outputs and that
  // done lasts one cycle
  task automatic run8(input string tag, input logic sub, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] expRes,
                      input logic expCout, input logic expOvf);
    int edges;
    int busyCycles;
    applyStimulus(1'b0, sub, a, b);
    waitDone(1'b0, edges, busyCycles);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd8);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'd8);
    checkOutput({tag, "_result"}, 32'(bus8.result), 32'(expRes));
    checkOutput({tag, "_cout"}, 32'(bus8.cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(bus8.ovf), 32'(expOvf));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
  endtask

  initial begin
    int doneCount;
    int edges;
    int busyCycles;
    int sum;
    int sa;
    int sb;
    int sr;
    logic [2:0] expRes3;
    logic       expCout3;
    logic       expOvf3;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
    bus3.start = 1'b0; bus3.sub = 1'b0; bus3.a = '0; bus3.b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   32'(bus8.busy),   32'd0);
    checkOutput("rst_done",   32'(bus8.done),   32'd0);
    checkOutput("rst_result", 32'(bus8.result), 32'd0);
    checkOutput("rst_cout",   32'(bus8.cout),   32'd0);
    checkOutput("rst_ovf",    32'(bus8.ovf),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 90 + 51 = 141: wraps into the sign bit, no unsigned carry
    run8("add_5a_33", 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1);
    // -1 + 1: unsigned carry out, no signed overflow
    run8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    // 16 - 32 borrows
    run8("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    // -128 - 1 overflows to +127, no borrow
    run8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Idle hold: outputs keep the last values, no spurious done
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_result", 32'(bus8.result), 32'h7F);
      checkOutput("hold_cout",   32'(bus8.cout),   32'd1);
      checkOutput("hold_ovf",    32'(bus8.ovf),    32'd1);
      checkOutput("hold_done",   32'(bus8.done),   32'd0);
    end

    // start re-pulsed during SHIFT (cycle 3) and DONE (cycle 9) is ignored
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h01);
    doneCount = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        doneCount++;
        checkOutput("ignore_result", 32'(bus8.result), 32'h02);
      end
      if (c == 3 || c == 9) begin
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
      end else begin
        bus8.start = 1'b0;
      end
    end
    checkOutput("ignore_done_count", 32'(doneCount), 32'd1);
    checkOutput("ignore_busy",       32'(bus8.busy), 32'd0);
    checkOutput("ignore_final",      32'(bus8.result), 32'h02);

    // Reset in the middle of an operation aborts without a done pulse
    applyStimulus(1'b0, 1'b0, 8'h55, 8'hAA);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",   32'(bus8.busy),   32'd0);
    checkOutput("abort_done",   32'(bus8.done),   32'd0);
    checkOutput("abort_result", 32'(bus8.result), 32'd0);
    checkOutput("abort_cout",   32'(bus8.cout),   32'd0);
    checkOutput("abort_ovf",    32'(bus8.ovf),    32'd0);
    doneCount = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus8.done) doneCount++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) doneCount++;
    end
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    run8("add_03_04", 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

    // 3-bit instance: every operand pair for add and sub against an
    // integer reference (unsigned carry, signed range check for overflow)
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          sa = (a >= 4) ? a - 8 : a;
          sb = (b >= 4) ? b - 8 : b;
          if (s == 0) begin
            sum      = a + b;
            expCout3 = (sum >= 8);
            sr       = sa + sb;
          end else begin
            sum      = a - b + 8;
            expCout3 = (a >= b);
            sr       = sa - sb;
          end
          expRes3 = 3'(sum);
          expOvf3 = (sr > 3) || (sr < -4);
          applyStimulus(1'b1, 1'(s), 8'(a), 8'(b));
          waitDone(1'b1, edges, busyCycles);
          checkOutput($sformatf("w3_%0d_%0d_%0d_lat", s, a, b), 32'(edges), 32'd3);
          checkOutput($sformatf("w3_%0d_%0d_%0d_res", s, a, b), 32'(bus3.result), 32'(expRes3));
          checkOutput($sformatf("w3_%0d_%0d_%0d_cout", s, a, b), 32'(bus3.cout), 32'(expCout3));
          checkOutput($sformatf("w3_%0d_%0d_%0d_ovf", s, a, b), 32'(bus3.ovf), 32'(expOvf3));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
